mutative_reconfig_sequencer: RTL

MUTATIVE_RECONFIG_SEQUENCER -- requirements
Module: mutative_reconfig_sequencer

---
 rtl/mutative_reconfig_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mutative_reconfig_sequencer.sv
// Sequences a cache associativity change: drain the CPU, flush every (set, way)
// line in order, then commit the new organisation in a single cycle.
module mutative_reconfig_sequencer #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned SET_W = $clog2(NUM_SETS),
    localparam int unsigned WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             switch_valid,
    input  logic             switch_dir,
    input  logic             cpu_req,
    input  logic             cache_ready,
    input  logic             flush_ack,
    output logic [1:0]       setup,
    output logic             cpu_stall,
    output logic             flush_req,
    output logic [SET_W-1:0] flush_set,
    output logic [WAY_W-1:0] flush_way,
    output logic             switch_ready,
    output logic             switch_reject,
    output logic [15:0]      reconfig_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_COMMIT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_setup;
    logic [1:0]       r_target;
    logic             r_cpu_stall;
    logic             r_switch_ready;
    logic             r_switch_reject;
    logic [15:0]      r_count;
    logic [SET_W-1:0] r_set;
    logic [WAY_W-1:0] r_way;
    logic             w_accept;
    logic             w_reject;
    logic             w_last_way;
    logic             w_last_line;

    assign w_last_way  = (r_way == WAY_W'(NUM_WAYS - 1));
    assign w_last_line = w_last_way && (r_set == SET_W'(NUM_SETS - 1));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (switch_valid) begin
                    if ((switch_dir && r_setup != 2'b11) || (!switch_dir && r_setup != 2'b00)) begin
                        w_accept = 1'b1;
                        w_next   = S_DRAIN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (cache_ready && !cpu_req) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_ack && w_last_line) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_setup         <= '0;
            r_target        <= '0;
            r_cpu_stall     <= 1'b0;
            r_switch_ready  <= 1'b0;
            r_switch_reject <= 1'b0;
            r_count         <= '0;
            r_set           <= '0;
            r_way           <= '0;
        end else begin
            r_state         <= w_next;
            // Stall is registered from the next state, so the accept cycle itself still lets a CPU request through.
            r_cpu_stall     <= (w_next != S_IDLE);
            r_switch_reject <= w_reject;
            r_switch_ready  <= (r_state == S_COMMIT);
            if (w_accept) begin
                r_target <= switch_dir ? (r_setup + 2'd1) : (r_setup - 2'd1);
            end
            if (r_state == S_DRAIN) begin
                r_set <= '0;
                r_way <= '0;
            end
            if (r_state == S_FLUSH && flush_ack) begin
                r_way <= w_last_way ? '0 : (r_way + 1'b1);
                if (w_last_way) begin
                    r_set <= r_set + 1'b1;
                end
            end
            if (r_state == S_COMMIT) begin
                r_setup <= r_target;
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign setup          = r_setup;
    assign cpu_stall      = r_cpu_stall;
    assign flush_req      = (r_state == S_FLUSH);
    assign flush_set      = flush_req ? r_set : '0;
    assign flush_way      = flush_req ? r_way : '0;
    assign switch_ready   = r_switch_ready;
    assign switch_reject  = r_switch_reject;
    assign reconfig_count = r_count;

endmodule
